// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes and the
// write/read channel state encodings of the register file.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface AXIL_IF #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport Master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport Slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file with per-register read-only
// masking, byte strobes and one-cycle write-commit pulses.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    REG_COUNT   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [REG_COUNT-1:0]  RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                  clk,
    input  logic                                  sync_rst,
    AXIL_IF.Slave                                 axil,
    output logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  reg_q,
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  reg_d,
    output logic [REG_COUNT-1:0]                  reg_wr_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    typedef struct packed {
        logic             ok;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Word index relative to BASE_ADDR; low byte-offset bits drop out.
    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        logic [ADDR_WIDTH-1:0] word;
        dec_t                  d;
        off   = addr - BASE_ADDR;
        word  = off >> LSB;
        d.ok  = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(REG_COUNT));
        d.idx = word[IDX_W-1:0];
        return d;
    endfunction

    wr_state_t                            r_wstate;
    logic                                 r_awready;
    logic                                 r_wready;
    logic                                 r_aw_have;
    logic                                 r_w_have;
    logic [ADDR_WIDTH-1:0]                r_awaddr;
    logic [DATA_WIDTH-1:0]                r_wdata;
    logic [STRB_WIDTH-1:0]                r_wstrb;
    logic                                 r_bvalid;
    axil_resp_t                           r_bresp;

    rd_state_t                            r_rstate;
    logic                                 r_arready;
    logic                                 r_rvalid;
    axil_resp_t                           r_rresp;
    logic [DATA_WIDTH-1:0]                r_rdata;

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] r_regs;
    logic [REG_COUNT-1:0]                 r_pulse;

    logic                                 w_aw_hs;
    logic                                 w_w_hs;
    logic                                 w_aw_ok;
    logic                                 w_w_ok;
    logic                                 w_commit;
    logic                                 w_wr_en;
    logic [ADDR_WIDTH-1:0]                w_waddr;
    logic [DATA_WIDTH-1:0]                w_wdata;
    logic [STRB_WIDTH-1:0]                w_wstrb;
    dec_t                                 w_wdec;
    axil_resp_t                           w_bresp;
    logic                                 w_ar_hs;
    dec_t                                 w_rdec;
    logic                                 w_unused;

    assign w_aw_hs  = axil.awvalid && r_awready;
    assign w_w_hs   = axil.wvalid && r_wready;
    assign w_aw_ok  = r_aw_have || w_aw_hs;
    assign w_w_ok   = r_w_have || w_w_hs;

    // Either half may come straight off the bus in the commit cycle.
    assign w_waddr  = r_aw_have ? r_awaddr : axil.awaddr;
    assign w_wdata  = r_w_have ? r_wdata : axil.wdata;
    assign w_wstrb  = r_w_have ? r_wstrb : axil.wstrb;
    assign w_wdec   = decode(w_waddr);

    assign w_commit = (r_wstate == W_IDLE) && w_aw_ok && w_w_ok;
    assign w_wr_en  = w_commit && w_wdec.ok && !RO_MASK[w_wdec.idx];

    always_comb begin
        w_bresp = OKAY;
        if (!w_wdec.ok) begin
            w_bresp = DECERR;
        end else if (RO_MASK[w_wdec.idx]) begin
            w_bresp = SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_bresp;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_have <= 1'b0;
                        r_w_have  <= 1'b0;
                    end else begin
                        r_awready <= !w_aw_ok;
                        r_wready  <= !w_w_ok;
                        if (w_aw_hs) begin
                            r_aw_have <= 1'b1;
                            r_awaddr  <= axil.awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_have <= 1'b1;
                            r_wdata  <= axil.wdata;
                            r_wstrb  <= axil.wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (axil.bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= RO_MASK[i] ? '0 : RESET_VALUE;
            end
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            if (w_wr_en) begin
                r_pulse[w_wdec.idx] <= 1'b1;
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (w_wstrb[b]) begin
                        r_regs[w_wdec.idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign w_ar_hs = axil.arvalid && r_arready;
    assign w_rdec  = decode(axil.araddr);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= OKAY;
            r_rdata   <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rstate  <= R_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        if (w_rdec.ok) begin
                            r_rresp <= OKAY;
                            r_rdata <= RO_MASK[w_rdec.idx] ?
                                       reg_d[w_rdec.idx] :
                                       r_regs[w_rdec.idx];
                        end else begin
                            r_rresp <= DECERR;
                            r_rdata <= '0;
                        end
                    end
                end
                R_RESP: begin
                    if (axil.rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign axil.awready = r_awready;
    assign axil.wready  = r_wready;
    assign axil.bvalid  = r_bvalid;
    assign axil.bresp   = r_bresp;
    assign axil.arready = r_arready;
    assign axil.rvalid  = r_rvalid;
    assign axil.rresp   = r_rresp;
    assign axil.rdata   = r_rdata;

    assign reg_q        = r_regs;
    assign reg_wr_pulse = r_pulse;

    // Protection bits carry no meaning for this block.
    assign w_unused = ^{axil.awprot, axil.arprot};

endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile: strobes, ordering, errors,
// backpressure and mid-transaction reset.
module tb_axil_regfile;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] RV   = 32'hA5A5_0000;

    logic                    clk = 1'b0;
    logic                    sync_rst;
    logic [15:0][31:0]       reg_q;
    logic [15:0][31:0]       reg_d;
    logic [15:0]             reg_wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    AXIL_IF #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    axil_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .REG_COUNT  (16),
        .BASE_ADDR  (BASE),
        .RO_MASK    (16'h0008),
        .RESET_VALUE(RV)
    ) dut (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .axil        (axil),
        .reg_q       (reg_q),
        .reg_d       (reg_d),
        .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input logic [31:0] a);
        axil.awvalid = 1'b1;
        axil.awaddr  = a;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        axil.wvalid = 1'b1;
        axil.wdata  = d;
        axil.wstrb  = s;
    endtask

    task automatic drive_ar(input logic [31:0] a);
        axil.arvalid = 1'b1;
        axil.araddr  = a;
    endtask

    task automatic drop_valids();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.arvalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        drive_aw(a);
        drive_w(d, s);
        tick();
        drop_valids();
    endtask

    task automatic rd(input logic [31:0] a);
        drive_ar(a);
        tick();
        drop_valids();
    endtask

    task automatic bdone();
        axil.bready = 1'b1;
        tick();
        axil.bready = 1'b0;
    endtask

    task automatic rdone();
        axil.rready = 1'b1;
        tick();
        axil.rready = 1'b0;
    endtask

    initial begin
        sync_rst     = 1'b1;
        reg_d        = '0;
        axil.awaddr  = '0;
        axil.awprot  = '0;
        axil.awvalid = 1'b0;
        axil.wdata   = '0;
        axil.wstrb   = '0;
        axil.wvalid  = 1'b0;
        axil.bready  = 1'b0;
        axil.araddr  = '0;
        axil.arprot  = '0;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b0;

        repeat (3) tick();
        chk("rst_awready", axil.awready, 0);
        chk("rst_wready", axil.wready, 0);
        chk("rst_arready", axil.arready, 0);
        chk("rst_bvalid", axil.bvalid, 0);
        chk("rst_rvalid", axil.rvalid, 0);
        chk("rst_rdata", axil.rdata, 0);
        chk("rst_pulse", reg_wr_pulse, 0);
        chk("rst_q0", reg_q[0], RV);
        chk("rst_q3_ro", reg_q[3], 0);
        sync_rst = 1'b0;
        tick();
        chk("post_awready", axil.awready, 1);
        chk("post_wready", axil.wready, 1);
        chk("post_arready", axil.arready, 1);

        // AW and W together to reg 2
        wr(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF);
        chk("w2_bvalid", axil.bvalid, 1);
        chk("w2_bresp", axil.bresp, 2'b00);
        chk("w2_q", reg_q[2], 32'hDEAD_BEEF);
        chk("w2_pulse", reg_wr_pulse, 16'h0004);
        chk("w2_awready", axil.awready, 0);
        bdone();
        chk("w2_pulse_off", reg_wr_pulse, 0);
        chk("w2_bvalid_off", axil.bvalid, 0);
        chk("w2_awready_back", axil.awready, 1);

        wr(BASE, 32'h1234_5678, 4'hF);
        chk("w0_q", reg_q[0], 32'h1234_5678);
        bdone();

        // W leads AW by three cycles, single byte lane
        drive_w(32'h0000_00AA, 4'h1);
        tick();
        axil.wvalid = 1'b0;
        chk("wl_wready", axil.wready, 0);
        chk("wl_awready", axil.awready, 1);
        chk("wl_bvalid0", axil.bvalid, 0);
        tick();
        tick();
        chk("wl_bvalid2", axil.bvalid, 0);
        chk("wl_q_hold", reg_q[0], 32'h1234_5678);
        drive_aw(BASE);
        tick();
        axil.awvalid = 1'b0;
        chk("wl_bvalid", axil.bvalid, 1);
        chk("wl_bresp", axil.bresp, 2'b00);
        chk("wl_q", reg_q[0], 32'h1234_56AA);
        chk("wl_pulse", reg_wr_pulse, 16'h0001);
        bdone();

        // Zero strobe commits without data change
        wr(BASE + 32'h8, 32'h0BAD_0BAD, 4'h0);
        chk("ws0_bresp", axil.bresp, 2'b00);
        chk("ws0_pulse", reg_wr_pulse, 16'h0004);
        chk("ws0_q", reg_q[2], 32'hDEAD_BEEF);
        bdone();

        // Read-only register
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        chk("ro_bresp", axil.bresp, 2'b10);
        chk("ro_pulse", reg_wr_pulse, 0);
        chk("ro_q", reg_q[3], 0);
        bdone();
        reg_d[3] = 32'h0000_0055;
        reg_d[2] = 32'h7777_7777;
        rd(BASE + 32'hC);
        chk("ro_rvalid", axil.rvalid, 1);
        chk("ro_rdata", axil.rdata, 32'h55);
        chk("ro_rresp", axil.rresp, 2'b00);
        chk("ro_arready", axil.arready, 0);
        rdone();
        chk("ro_rvalid_off", axil.rvalid, 0);
        chk("ro_arready_back", axil.arready, 1);
        rd(BASE + 32'h8);
        chk("rw_rdata", axil.rdata, 32'hDEAD_BEEF);
        rdone();

        // Read and write of reg 2 in the same cycle
        drive_ar(BASE + 32'h8);
        wr(BASE + 32'h8, 32'h1111_1111, 4'hF);
        chk("rw_same_rdata", axil.rdata, 32'hDEAD_BEEF);
        chk("rw_same_q", reg_q[2], 32'h1111_1111);
        axil.bready = 1'b1;
        rdone();
        axil.bready = 1'b0;

        rd(BASE + 32'hB);
        chk("unal_rdata", axil.rdata, 32'h1111_1111);
        chk("unal_rresp", axil.rresp, 2'b00);
        rdone();
        rd(BASE - 32'h4);
        chk("below_rresp", axil.rresp, 2'b11);
        chk("below_rdata", axil.rdata, 0);
        rdone();

        // Out of range on both channels, then hold responses
        drive_ar(BASE + 32'h40);
        wr(BASE + 32'h40, 32'hCCCC_CCCC, 4'hF);
        chk("oor_bresp", axil.bresp, 2'b11);
        chk("oor_rresp", axil.rresp, 2'b11);
        chk("oor_rdata", axil.rdata, 0);
        chk("oor_pulse", reg_wr_pulse, 0);
        chk("oor_q0", reg_q[0], 32'h1234_56AA);
        chk("oor_q2", reg_q[2], 32'h1111_1111);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_bvalid", axil.bvalid, 1);
            chk("hold_rvalid", axil.rvalid, 1);
            chk("hold_bresp", axil.bresp, 2'b11);
            chk("hold_rresp", axil.rresp, 2'b11);
            chk("hold_rdata", axil.rdata, 0);
            chk("hold_readies",
                {axil.awready, axil.wready, axil.arready}, 0);
        end
        axil.bready = 1'b1;
        rdone();
        axil.bready = 1'b0;
        chk("rel_bvalid", axil.bvalid, 0);
        chk("rel_rvalid", axil.rvalid, 0);

        // Reset while a write response is pending
        wr(BASE + 32'h4, 32'h0000_CAFE, 4'hF);
        chk("pre_rst_bvalid", axil.bvalid, 1);
        chk("pre_rst_q1", reg_q[1], 32'h0000_CAFE);
        sync_rst = 1'b1;
        tick();
        chk("mrst_bvalid", axil.bvalid, 0);
        chk("mrst_awready", axil.awready, 0);
        chk("mrst_q0", reg_q[0], RV);
        chk("mrst_q1", reg_q[1], RV);
        chk("mrst_q2", reg_q[2], RV);
        chk("mrst_q3", reg_q[3], 0);
        sync_rst = 1'b0;
        tick();
        chk("mrst_awready_back", axil.awready, 1);
        chk("mrst_bvalid_idle", axil.bvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
